// File: rtl/mips_defs.sv
// Shared MIPS-subset definitions: branch condition codes, fetch FSM encoding
// and the default boot address, used by the fetch unit and the decoder.
package mips_defs;

  typedef enum logic [2:0] {
    COND_NONE = 3'b000,
    COND_BEQ  = 3'b001,
    COND_BNE  = 3'b010,
    COND_BGEZ = 3'b011,
    COND_BGTZ = 3'b100,
    COND_BLEZ = 3'b101,
    COND_BLTZ = 3'b110,
    COND_RSVD = 3'b111
  } cond_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_ISSUE = 2'b10
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Branch resolution from the ALU flags; NONE and RSVD are never taken.
  function automatic logic branch_taken(input cond_t c, input logic zero,
                                        input logic neg);
    case (c)
      COND_BEQ:  return zero;
      COND_BNE:  return !zero;
      COND_BGEZ: return !neg;
      COND_BGTZ: return !neg && !zero;
      COND_BLEZ: return neg || zero;
      COND_BLTZ: return neg;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: jump target, taken-branch target or
// sequential fall-through, all in 32-bit modulo arithmetic.
module npc_calc
  import mips_defs::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic        jump,
  input  cond_t       condition,
  input  logic        alu_zero,
  input  logic        alu_neg,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic signed [31:0] br_off;

  // Word offset from imm16, sign-extended and scaled to a byte offset.
  function automatic logic signed [31:0] word_offset(input logic signed [15:0] imm);
    logic signed [31:0] ext;
    ext = 32'(imm);
    return ext <<< 2;
  endfunction

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = word_offset($signed(ir[15:0]));

  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
    else if (branch_taken(condition, alu_zero, alu_neg))
      next_pc = pc_plus4 + $unsigned(br_off);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests a word at PC, holds it in IR while execute
// consumes it, then redirects PC (no delay slot) and fetches again.
module instr_fetch
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        Jump,
  input  logic [2:0]  condition,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        exec_done,
  output logic [5:0]  op,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [4:0]  Shamt,
  output logic [5:0]  Func,
  output logic [15:0] imm16,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  ir;
  logic [31:0]  next_pc;

  npc_calc u_npc (
    .pc        (pc),
    .ir        (ir),
    .jump      (Jump),
    .condition (cond_t'(condition)),
    .alu_zero  (alu_zero),
    .alu_neg   (alu_neg),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
  );

  // Reset wins over a same-edge ack or exec_done: the in-flight word is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_REQ;
          imem_req <= 1'b1;
        end
        ST_REQ: begin
          if (imem_ack) begin
            ir          <= imem_rdata;
            state       <= ST_ISSUE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (exec_done) begin
            pc          <= next_pc;
            state       <= ST_REQ;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign op        = ir[31:26];
  assign Rs        = ir[25:21];
  assign Rt        = ir[20:16];
  assign Rd        = ir[15:11];
  assign Shamt     = ir[10:6];
  assign Func      = ir[5:0];
  assign imm16     = ir[15:0];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first instruction address after reset.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the synchronous, active-high reset.
REQ-004 Ports imem_req (output, 1) and imem_addr (output, 32) SHALL form the instruction-memory read request.
REQ-005 Ports imem_ack (input, 1) and imem_rdata (input, 32) SHALL return the instruction word; rdata is valid when ack=1.
REQ-006 Ports Jump (input, 1) and condition (input, 3) SHALL carry the decoder's control for the issued instruction.
REQ-007 Ports alu_zero (input, 1) and alu_neg (input, 1) SHALL carry the ALU zero and sign flags for the issued instruction.
REQ-008 Port exec_done, input, 1, SHALL signal that execute has consumed the issued instruction.
REQ-009 Outputs op (6), Rs, Rt, Rd and Shamt (5 each), Func (6) and imm16 (16) SHALL be bit-fields of the held instruction register (IR): [31:26], [25:21], [20:16], [15:11], [10:6], [5:0] and [15:0].
REQ-010 Outputs instr_valid (1), pc_out (32) and pc_plus4 (32) SHALL give the issued-instruction qualifier, its address and its address + 4.

Function
REQ-011 The FSM SHALL have states IDLE, REQ and ISSUE.
REQ-012 IDLE SHALL move to REQ unconditionally on the next edge.
REQ-013 In REQ, imem_req=1 and imem_addr=PC SHALL both be held stable until the edge where imem_ack=1.
REQ-014 On that ack edge, IR SHALL capture imem_rdata and the FSM SHALL enter ISSUE.
REQ-015 instr_valid SHALL be 1 only in ISSUE, so it first asserts in the cycle after the ack.
REQ-016 In ISSUE, IR, PC and all field outputs SHALL hold stable until exec_done=1.
REQ-017 On the exec_done edge, PC SHALL load next-PC and the FSM SHALL return to REQ; minimum loop is 2 cycles per instruction with a zero-wait memory.
REQ-018 imem_ack outside REQ, and exec_done outside ISSUE, SHALL be ignored.
REQ-019 Next-PC priority: Jump=1 SHALL select {pc_plus4[31:28], IR[25:0], 2'b00}; else a taken branch SHALL select pc_plus4 + (sign-extended imm16 << 2); else pc_plus4.
REQ-020 Branch taken SHALL be decoded from condition as follows:
 - 001 beq: alu_zero
 - 010 bne: !alu_zero
 - 011 bgez: !alu_neg
 - 100 bgtz: !alu_neg && !alu_zero
 - 101 blez: alu_neg || alu_zero
 - 110 bltz: alu_neg
 - 000 and 111: never taken
REQ-021 There SHALL be no branch delay slot; the redirect is applied to the very next fetch.
REQ-022 All PC arithmetic SHALL be 32-bit modulo, so 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000; PC[1:0] is always 2'b00.
REQ-023 Flags and condition SHALL be sampled only on the exec_done edge.

Reset
REQ-024 When rst=1 at an edge, the block SHALL set PC=RESET_PC, IR=0 and state=IDLE, with imem_req=0 and instr_valid=0 from the following cycle.
REQ-025 rst SHALL override a simultaneous imem_ack or exec_done; the in-flight instruction is discarded and no PC update occurs.
REQ-026 Reset values SHALL be: pc_out=RESET_PC, pc_plus4=RESET_PC+4, all field outputs 0.

Structure
REQ-027 The condition codes (3-bit), FSM state encoding and the RESET_PC default SHALL live in shared package mips_defs, also used by the decoder.
REQ-028 Branch evaluation and target computation SHALL be a combinational sub-module, npc_calc; the FSM, PC and IR stay in instr_fetch.

Verification
REQ-029 Reset then zero-wait memory returning 32'h2408_0005, with exec_done each ISSUE cycle -> imem_addr sequence 0, 4, 8; instr_valid pulses every second cycle; op=6'h09 and Rt=8.
REQ-030 Memory ack delayed 3 cycles -> imem_req and imem_addr held constant for 3 cycles; instr_valid only after the ack.
REQ-031 PC=32'h100, IR imm16=16'hFFFE, condition=001, alu_zero=1 -> next imem_addr=32'hFC; with alu_zero=0 -> 32'h104.
REQ-032 PC=32'h1000_0040, Jump=1, IR[25:0]=26'h0000100 -> next imem_addr=32'h1000_0400, regardless of condition.
REQ-033 Sweep condition 000-111 against all four flag combinations -> taken matches the REQ-020 table exactly.
REQ-034 rst asserted in the same cycle as imem_ack, and separately in the same cycle as exec_done -> IR not loaded / PC not updated; fetch restarts at RESET_PC.
